// File: rtl/add36_arbiter.sv
// add36_arbiter: two requesters share one 36-bit ripple-carry adder through an
// arbiter. The sum is captured into a one-entry registered response buffer
// with a valid/ready handshake. Latency is 1 cycle, and a full buffer that is
// drained and refilled on the same edge sustains one operation per cycle.
// Optional feature macro: ADD36_CHAIN_EN. It adds per-requester carry
// registers so that wider additions can be chained from 36-bit operations.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   reqN_valid / reqN_ready           request handshake, N = 0, 1
//   reqN_A, reqN_B, reqN_Cin          operands and carry-in
//   reqN_chain                        use stored carry (ADD36_CHAIN_EN only)
//   rsp_valid / rsp_ready             response handshake
//   rsp_S, rsp_Cout, rsp_id           registered sum, carry-out, issuing requester
// Parameter RR_EN: 1 = round-robin, 0 = fixed priority (requester 0 wins).

module rca_36b (
   input  logic [35:0] a,
   input  logic [35:0] b,
   input  logic        cin,
   output logic [35:0] s,
   output logic        cout
);
   always_comb begin
      logic c;
      c = cin;
      s = '0;
      for (int i = 0; i < 36; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

module add36_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [35:0] req0_A,
   input  logic [35:0] req0_B,
   input  logic        req0_Cin,
   input  logic        req0_chain,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [35:0] req1_A,
   input  logic [35:0] req1_B,
   input  logic        req1_Cin,
   input  logic        req1_chain,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [35:0] rsp_S,
   output logic        rsp_Cout,
   output logic        rsp_id
);
   typedef enum logic {RSP_EMPTY = 1'b0, RSP_FULL = 1'b1} rsp_state_e;

   rsp_state_e  state_q, state_d;
   logic [35:0] rsp_s_q, rsp_s_d;
   logic        rsp_cout_q, rsp_cout_d;
   logic        rsp_id_q, rsp_id_d;
   logic        last_q, last_d;

   logic        slot_free;
   logic        grant;
   logic        accept;
   logic [35:0] op_a, op_b;
   logic        cin_eff;
   logic [35:0] sum_s;
   logic        sum_cout;

`ifdef ADD36_CHAIN_EN
   logic carry0_q, carry0_d;
   logic carry1_q, carry1_d;
`else
   // Chain requests have no effect when carry registers are not built.
   logic unused_chain;
   assign unused_chain = req0_chain ^ req1_chain;
`endif

   rca_36b u_rca (
      .a    (op_a),
      .b    (op_b),
      .cin  (cin_eff),
      .s    (sum_s),
      .cout (sum_cout)
   );

   // Arbitration and operand selection.
   always_comb begin
      slot_free = (state_q == RSP_EMPTY) || rsp_ready;
      // With a single requester valid, the grant goes to it. With both
      // valid, round-robin picks the one that did not win last.
      if (RR_EN != 0 && req0_valid && req1_valid) begin
         grant = ~last_q;
      end else begin
         grant = ~req0_valid;
      end
      // No handshake completes while reset is held.
      req0_ready = !rst && slot_free && req0_valid && !grant;
      req1_ready = !rst && slot_free && req1_valid &&  grant;
      accept     = req0_ready || req1_ready;

      op_a = grant ? req1_A : req0_A;
      op_b = grant ? req1_B : req0_B;
`ifdef ADD36_CHAIN_EN
      if (grant ? req1_chain : req0_chain) begin
         cin_eff = grant ? carry1_q : carry0_q;
      end else begin
         cin_eff = grant ? req1_Cin : req0_Cin;
      end
`else
      cin_eff = grant ? req1_Cin : req0_Cin;
`endif
   end

   // Response buffer next state. A drain and an accept on the same edge
   // simply overwrite the buffer, leaving no bubble.
   always_comb begin
      state_d    = state_q;
      rsp_s_d    = rsp_s_q;
      rsp_cout_d = rsp_cout_q;
      rsp_id_d   = rsp_id_q;
      last_d     = last_q;
      if (accept) begin
         state_d    = RSP_FULL;
         rsp_s_d    = sum_s;
         rsp_cout_d = sum_cout;
         rsp_id_d   = grant;
         last_d     = grant;
      end else if (rsp_ready) begin
         state_d    = RSP_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RSP_EMPTY;
         rsp_s_q    <= '0;
         rsp_cout_q <= 1'b0;
         rsp_id_q   <= 1'b0;
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         rsp_s_q    <= rsp_s_d;
         rsp_cout_q <= rsp_cout_d;
         rsp_id_q   <= rsp_id_d;
         last_q     <= last_d;
      end
   end

`ifdef ADD36_CHAIN_EN
   always_comb begin
      carry0_d = carry0_q;
      carry1_d = carry1_q;
      if (req0_ready) carry0_d = sum_cout;
      if (req1_ready) carry1_d = sum_cout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry0_q <= 1'b0;
         carry1_q <= 1'b0;
      end else begin
         carry0_q <= carry0_d;
         carry1_q <= carry1_d;
      end
   end
`endif

   assign rsp_valid = (state_q == RSP_FULL);
   assign rsp_S     = rsp_s_q;
   assign rsp_Cout  = rsp_cout_q;
   assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_add36_arbiter.sv
// Bench for add36_arbiter. It covers table-driven single operations,
// directed multi-cycle sequences, and a random run.
// A reference model predicts readies and sums, and a scoreboard queue
// holds the expected responses.
module tb_add36_arbiter;
   logic        clk = 0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_Cin, req0_chain;
   logic [35:0] req0_A, req0_B;
   logic        req1_valid, req1_ready, req1_Cin, req1_chain;
   logic [35:0] req1_A, req1_B;
   logic        rsp_valid, rsp_ready, rsp_Cout, rsp_id;
   logic [35:0] rsp_S;
   logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_Cout, fp_rsp_id;
   logic [35:0] fp_rsp_S;

   always #5 clk = ~clk;

   add36_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
      .req0_Cin(req0_Cin), .req0_chain(req0_chain),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
      .req1_Cin(req1_Cin), .req1_chain(req1_chain),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_S(rsp_S),
      .rsp_Cout(rsp_Cout), .rsp_id(rsp_id)
   );

   add36_arbiter #(.RR_EN(0)) dut_fp (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_A(req0_A), .req0_B(req0_B),
      .req0_Cin(req0_Cin), .req0_chain(req0_chain),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_A(req1_A), .req1_B(req1_B),
      .req1_Cin(req1_Cin), .req1_chain(req1_chain),
      .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_S(fp_rsp_S),
      .rsp_Cout(fp_rsp_Cout), .rsp_id(fp_rsp_id)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state
   logic        m_full, m_last, m_carry0, m_carry1;
   logic        acc0, acc1;
   logic [37:0] sb_q[$];   // {id, cout, sum}

   typedef struct {
      logic [35:0] a;
      logic [35:0] b;
      logic        cin;
      logic        port;
      logic [35:0] exp_s;
      logic        exp_c;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_full = 0; m_last = 1; m_carry0 = 0; m_carry1 = 0;
      acc0 = 0; acc1 = 0;
      sb_q.delete();
   endtask

   // Called just after a negedge with inputs driven. It checks the
   // combinational outputs against the model, advances through the posedge,
   // and returns at the next negedge.
   task automatic cycle();
      logic        sf, g, e0, e1, ci;
      logic [36:0] sum;
      logic [37:0] exp_r;
      #1;
      sf = !m_full || rsp_ready;
      g  = (req0_valid && req1_valid) ? ~m_last : ~req0_valid;
      e0 = sf && req0_valid && !g;
      e1 = sf && req1_valid && g;
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("rsp_valid", rsp_valid, m_full);
      if (m_full && rsp_ready) begin
         chk("sb_nonempty", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            exp_r = sb_q.pop_front();
            chk("sb_result", {rsp_id, rsp_Cout, rsp_S}, exp_r);
         end
      end
      acc0 = e0; acc1 = e1;
      if (e0 || e1) begin
`ifdef ADD36_CHAIN_EN
         if (g ? req1_chain : req0_chain) ci = g ? m_carry1 : m_carry0;
         else ci = g ? req1_Cin : req0_Cin;
`else
         ci = g ? req1_Cin : req0_Cin;
`endif
         sum = g ? ({1'b0, req1_A} + {1'b0, req1_B} + {36'd0, ci})
                 : ({1'b0, req0_A} + {1'b0, req0_B} + {36'd0, ci});
         sb_q.push_back({g, sum});
         if (g) m_carry1 = sum[36]; else m_carry0 = sum[36];
         m_last = g;
         m_full = 1;
      end else if (rsp_ready) begin
         m_full = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive0(input logic v, input logic [35:0] a, input logic [35:0] b,
                         input logic c, input logic ch);
      req0_valid = v; req0_A = a; req0_B = b; req0_Cin = c; req0_chain = ch;
   endtask

   task automatic drive1(input logic v, input logic [35:0] a, input logic [35:0] b,
                         input logic c, input logic ch);
      req1_valid = v; req1_A = a; req1_B = b; req1_Cin = c; req1_chain = ch;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [37:0] held;
      logic        exp_g;
      tbl[0] = '{36'hF_FFFF_FFFF, 36'h1,           1'b0, 1'b0, 36'h0,           1'b1};
      tbl[1] = '{36'h1_2345_6789, 36'h1_1111_1111, 1'b1, 1'b1, 36'h2_3456_789B, 1'b0};
      tbl[2] = '{36'h8_0000_0000, 36'h8_0000_0000, 1'b0, 1'b0, 36'h0,           1'b1};
      tbl[3] = '{36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b1, 1'b1, 36'hF_FFFF_FFFF, 1'b1};
      tbl[4] = '{36'h0,           36'h0,           1'b1, 1'b0, 36'h1,           1'b0};
      tbl[5] = '{36'hA_BCDE_F012, 36'h0_0000_0FEE, 1'b0, 1'b1, 36'hA_BCDF_0000, 1'b0};

      rst = 1; rsp_ready = 0;
      drive0(0, 0, 0, 0, 0);
      drive1(0, 0, 0, 0, 0);
      model_reset();
      @(negedge clk); @(negedge clk);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_S", rsp_S, 0);
      chk("reset_rsp_Cout", rsp_Cout, 0);
      chk("reset_rsp_id", rsp_id, 0);
      rst = 0;
      @(negedge clk);

      // Table vectors: one operation at a time, result checked next cycle
      rsp_ready = 1;
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].port) drive1(1, tbl[i].a, tbl[i].b, tbl[i].cin, 0);
         else             drive0(1, tbl[i].a, tbl[i].b, tbl[i].cin, 0);
         cycle();
         drive0(0, 0, 0, 0, 0);
         drive1(0, 0, 0, 0, 0);
         #1;
         chk("tbl_valid", rsp_valid, 1);
         chk("tbl_S", rsp_S, tbl[i].exp_s);
         chk("tbl_Cout", rsp_Cout, tbl[i].exp_c);
         chk("tbl_id", rsp_id, tbl[i].port);
      end
      cycle();

      // Both requesters valid continuously: grants alternate 0,1,0,1...
      drive0(1, 36'h10, 36'h1, 0, 0);
      drive1(1, 36'h20, 36'h2, 0, 0);
      for (int i = 0; i < 6; i++) begin
         exp_g = i[0];
         #1;
         chk("alt_req1_ready", req1_ready, exp_g);
         chk("alt_req0_ready", req0_ready, !exp_g);
         chk("fp_req0_ready", fp_req0_ready, 1);
         chk("fp_req1_ready", fp_req1_ready, 0);
         if (i > 0) chk("fp_rsp_id", fp_rsp_id, 0);
         cycle();
      end
      drive0(0, 0, 0, 0, 0);
      drive1(0, 0, 0, 0, 0);
      cycle();

      // Fill the buffer, stall for 3 cycles, then drain and accept on the same edge
      drive0(1, 36'h5, 36'h7, 0, 0);
      cycle();
      rsp_ready = 0;
      drive0(1, 36'h100, 36'h200, 0, 0);
      drive1(1, 36'h10, 36'h20, 0, 0);
      #1 held = {rsp_id, rsp_Cout, rsp_S};
      for (int i = 0; i < 3; i++) begin
         chk("stall_hold", {rsp_id, rsp_Cout, rsp_S}, held);
         cycle();
      end
      rsp_ready = 1;
      cycle();
      drive0(0, 0, 0, 0, 0);
      drive1(0, 0, 0, 0, 0);
      #1;
      chk("stall_new_valid", rsp_valid, 1);
      chk("stall_new_S", rsp_S, 36'h30);
      chk("stall_new_id", rsp_id, 1);
      cycle();

      // Chained 72-bit add, with a req1 operation interleaved
      drive0(1, 36'hF_FFFF_FFFF, 36'h1, 0, 0);
      cycle();
      drive0(0, 0, 0, 0, 0);
      #1;
      chk("chain_lo_S", rsp_S, 0);
      chk("chain_lo_Cout", rsp_Cout, 1);
      drive1(1, 36'h5, 36'h6, 0, 0);
      cycle();
      drive1(0, 0, 0, 0, 0);
      drive0(1, 36'h0, 36'h0, 0, 1);
      cycle();
      drive0(0, 0, 0, 0, 0);
      #1;
`ifdef ADD36_CHAIN_EN
      chk("chain_hi_S", rsp_S, 1);
`else
      chk("chain_hi_S", rsp_S, 0);
`endif
      chk("chain_hi_Cout", rsp_Cout, 0);
      chk("chain_hi_id", rsp_id, 0);
      cycle();

      // Reset mid-operation: held result discarded, carries cleared
      drive0(1, 36'hF_FFFF_FFFF, 36'h1, 0, 0);
      cycle();
      rsp_ready = 0;
      drive0(1, 36'h0, 36'h0, 0, 1);
      drive1(1, 36'h3, 36'h4, 0, 0);
      #1;
      chk("pre_rst_valid", rsp_valid, 1);
      rst = 1;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_rsp_S", rsp_S, 0);
      model_reset();
      @(posedge clk); @(negedge clk);
      rst = 0;
      rsp_ready = 1;
      cycle();
      drive0(0, 0, 0, 0, 0);
      drive1(0, 0, 0, 0, 0);
      #1;
      chk("post_rst_id", rsp_id, 0);
      chk("post_rst_S", rsp_S, 0);
      chk("post_rst_Cout", rsp_Cout, 0);
      cycle();

      // Random traffic. Operands are held until the operation is accepted.
      for (int i = 0; i < 400; i++) begin
         if (!req0_valid || acc0)
            drive0(1'($urandom_range(0, 1)), {4'($urandom), 32'($urandom)},
                   {4'($urandom), 32'($urandom)}, 1'($urandom), 1'($urandom));
         if (!req1_valid || acc1)
            drive1(1'($urandom_range(0, 1)), {4'($urandom), 32'($urandom)},
                   {4'($urandom), 32'($urandom)}, 1'($urandom), 1'($urandom));
         rsp_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      drive0(0, 0, 0, 0, 0);
      drive1(0, 0, 0, 0, 0);
      rsp_ready = 1;
      cycle();
      cycle();
      chk("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
